// File: rtl/edge_norm_div.sv
// Normalisation stage of the edge-preserving filter: divides the weighted pixel sum
// by the weight sum through a PIX_W-stage restoring divider, then rounds and saturates.
module edge_norm_div #(
    parameter int NUM_W = 20,
    parameter int DEN_W = 12,
    parameter int PIX_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [NUM_W-1:0] num,
    input  logic [DEN_W-1:0] den,
    input  logic [PIX_W-1:0] ctr,
    output logic             out_valid,
    output logic [PIX_W-1:0] pix_out
);
    // One guard bit keeps den<<PIX_W representable for the range check.
    localparam int RW = NUM_W + 1;

    // Index 0 is S0; index k is the register after divider stage k.
    logic [RW-1:0]    rem_r [0:PIX_W];
    logic [PIX_W-1:0] quo_r [0:PIX_W];
    logic [DEN_W-1:0] den_r [0:PIX_W];
    logic [PIX_W-1:0] ctr_r [0:PIX_W];
    logic [PIX_W:0]   sat_r;
    logic [PIX_W:0]   zero_r;
    logic [PIX_W:0]   vld_r;

    logic             sat_s;
    logic [RW-1:0]    dsh_s  [1:PIX_W];
    logic [RW:0]      diff_s [1:PIX_W];
    logic [PIX_W:1]   ge_s;

    logic [RW:0]      two_rem_s;
    logic [RW:0]      den_ext_s;
    logic [PIX_W-1:0] rnd_pix_s;

    logic [PIX_W-1:0] s9_pix_r;
    logic             s9_vld_r;
    logic [PIX_W-1:0] pix_out_r;
    logic             out_valid_r;

    // Range check on the raw inputs: quotient would exceed PIX_W bits.
    always_comb begin
        sat_s = (RW'(num) >= (RW'(den) << PIX_W));
    end

    // Per-stage trial subtraction; the borrow out doubles as the compare result.
    always_comb begin
        for (int k = 1; k <= PIX_W; k++) begin
            dsh_s[k]  = RW'(den_r[k-1]) << (PIX_W - k);
            diff_s[k] = {1'b0, rem_r[k-1]} - {1'b0, dsh_s[k]};
            ge_s[k]   = ~diff_s[k][RW];
        end
    end

    // S0 capture and divider stages S1..S8.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k <= PIX_W; k++) begin
                rem_r[k] <= '0;
                quo_r[k] <= '0;
                den_r[k] <= '0;
                ctr_r[k] <= '0;
            end
            sat_r  <= '0;
            zero_r <= '0;
            vld_r  <= '0;
        end else begin
            rem_r[0]  <= RW'(num);
            quo_r[0]  <= '0;
            den_r[0]  <= den;
            ctr_r[0]  <= ctr;
            sat_r[0]  <= sat_s;
            zero_r[0] <= (den == {DEN_W{1'b0}});
            vld_r[0]  <= in_valid;
            for (int k = 1; k <= PIX_W; k++) begin
                if (ge_s[k]) begin
                    rem_r[k] <= diff_s[k][RW-1:0];
                    quo_r[k] <= quo_r[k-1] | (PIX_W'(1) << (PIX_W - k));
                end else begin
                    rem_r[k] <= rem_r[k-1];
                    quo_r[k] <= quo_r[k-1];
                end
                den_r[k]  <= den_r[k-1];
                ctr_r[k]  <= ctr_r[k-1];
                sat_r[k]  <= sat_r[k-1];
                zero_r[k] <= zero_r[k-1];
                vld_r[k]  <= vld_r[k-1];
            end
        end
    end

    // Result select: zero weight falls back to the centre pixel; ties round up, 255.5 clamps.
    always_comb begin
        two_rem_s = {rem_r[PIX_W], 1'b0};
        den_ext_s = (RW + 1)'(den_r[PIX_W]);
        rnd_pix_s = quo_r[PIX_W];
        if (zero_r[PIX_W]) begin
            rnd_pix_s = ctr_r[PIX_W];
        end else if (sat_r[PIX_W]) begin
            rnd_pix_s = {PIX_W{1'b1}};
        end else if ((two_rem_s >= den_ext_s) && (quo_r[PIX_W] != {PIX_W{1'b1}})) begin
            rnd_pix_s = quo_r[PIX_W] + PIX_W'(1);
        end else begin
            rnd_pix_s = quo_r[PIX_W];
        end
    end

    // S9 register holding the rounded result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s9_pix_r <= '0;
            s9_vld_r <= 1'b0;
        end else begin
            s9_pix_r <= rnd_pix_s;
            s9_vld_r <= vld_r[PIX_W];
        end
    end

    // Output register: pix_out only moves when a valid result arrives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_out_r   <= '0;
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= s9_vld_r;
            if (s9_vld_r) begin
                pix_out_r <= s9_pix_r;
            end else begin
                pix_out_r <= pix_out_r;
            end
        end
    end

    assign pix_out   = pix_out_r;
    assign out_valid = out_valid_r;

endmodule

// File: tb/tb_edge_norm_div.sv
// Scoreboard bench for edge_norm_div: stimulus pushes expected pixels and due cycles,
// a negedge monitor pops and compares whenever out_valid is seen.
module tb_edge_norm_div;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [19:0] num = '0;
    logic [11:0] den = '0;
    logic [7:0]  ctr = '0;
    logic        out_valid;
    logic [7:0]  pix_out;

    int n_vec = 0;
    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    int hold_pix = 0;
    int exp_q[$];
    int due_q[$];

    edge_norm_div dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .num      (num),
        .den      (den),
        .ctr      (ctr),
        .out_valid(out_valid),
        .pix_out  (pix_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: nearest integer of num/den with ties up, capped at 255.
    function automatic int ref_pix(input int n, input int d, input int c);
        int q;
        if (d == 0) return c;
        if (n >= d * 256) return 255;
        q = (2 * n + d) / (2 * d);
        return (q > 255) ? 255 : q;
    endfunction

    task automatic check(input string nm, input int act, input int req);
        n_chk++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, cyc, act, req);
        end
    endtask

    // exp < 0 selects the reference model; otherwise the given constant is expected.
    task automatic send(input bit v, input int n, input int d, input int c, input int exp);
        @(negedge clk);
        in_valid = v;
        num = 20'(n);
        den = 12'(d);
        ctr = 8'(c);
        if (v) begin
            exp_q.push_back((exp < 0) ? ref_pix(n, d, c) : exp);
            due_q.push_back(cyc + 11);
            n_vec++;
        end
    endtask

    task automatic send_rand(input bit v);
        send(v, int'($urandom_range(585225, 0)), int'($urandom_range(2295, 1)),
             int'($urandom_range(255, 0)), -1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) send(1'b0, 0, 0, 0, -1);
    endtask

    // Monitor: reset state, in-order results with exact latency, hold during gaps.
    always @(negedge clk) begin
        int e;
        int d;
        if (!rst_n) begin
            check("rst_valid", int'(out_valid), 0);
            check("rst_pix", int'(pix_out), 0);
        end else if (out_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out", 1, 0);
            end else begin
                e = exp_q.pop_front();
                d = due_q.pop_front();
                check("pix", int'(pix_out), e);
                check("latency", cyc, d);
                hold_pix = e;
            end
        end else begin
            check("hold", int'(pix_out), hold_pix);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;

        send(1'b1, 2550, 10, 0, 255);
        send(1'b1, 1000, 9, 0, 111);
        send(1'b1, 1004, 9, 0, 112);
        send(1'b1, 5, 10, 0, 1);
        send(1'b1, 2555, 10, 0, 255);
        send(1'b1, 2560, 10, 0, 255);
        send(1'b1, 1234, 0, 8'h5A, 8'h5A);
        send(1'b1, 0, 0, 0, 0);
        send(1'b1, 0, 2295, 77, 0);
        send(1'b1, 1048575, 1, 3, 255);
        send(1'b1, 2295 * 200, 2295, 9, 200);
        idle(3);

        for (int i = 0; i < 12; i++) send_rand(1'b1);
        send_rand(1'b1); send_rand(1'b0); send_rand(1'b0); send_rand(1'b1);
        send_rand(1'b1); send_rand(1'b0); send_rand(1'b1);
        for (int i = 0; i < 20; i++) send_rand(($urandom_range(1, 0) == 1) ? 1'b1 : 1'b0);
        idle(14);

        // Reset mid-stream: three samples in flight are discarded.
        send_rand(1'b1); send_rand(1'b1); send_rand(1'b1);
        idle(1);
        @(negedge clk);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        exp_q.delete();
        due_q.delete();
        hold_pix = 0;
        #1;
        check("rst_async_valid", int'(out_valid), 0);
        check("rst_async_pix", int'(pix_out), 0);
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        idle(1);
        send(1'b1, 1004, 9, 0, 112);
        idle(16);

        check("drain", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/edge_norm_div.md
# edge_norm_div

Normalisation stage of the edge-preserving filter datapath. It sits directly downstream of the 9-tap pipelined weighted-sum adder. It takes the 20-bit weighted pixel sum and the matching 12-bit sum of the nine weights, and divides the first by the second. The result is an 8-bit filtered pixel with round-half-up and saturation, produced by a fully pipelined restoring divider at one pixel per clock.

## Interface
- NUM_W, 20, numerator width (weighted sum from the adder); only the default is verified
- DEN_W, 12, denominator width (sum of nine 8-bit weights, max 2295)
- PIX_W, 8, output pixel width; the quotient stage count equals PIX_W
- clk  input  1  clock, rising-edge
- rst_n  input  1  reset, asynchronous, active-low
- in_valid  input  1  num/den/ctr qualify this cycle
- num  input  NUM_W  weighted sum, unsigned
- den  input  DEN_W  weight sum, unsigned
- ctr  input  PIX_W  centre pixel of the window; fallback when den==0
- out_valid  output  1  pix_out carries a new result this cycle
- pix_out  output  PIX_W  filtered pixel, unsigned

## Operation
- **Alignment.** The caller presents num, den and ctr in the same cycle as in_valid. The upstream adder's register stage is the caller's responsibility.
- **Stage S0 (range check).** Register the following:
  - den, ctr, in_valid;
  - r = num;
  - sat = (num >= den<<PIX_W);
  - z = (den==0).
- **Stages S1..S8.** Stage k handles bit b = PIX_W-k.
  - If r >= den<<b, then r -= den<<b and q[b] = 1; otherwise q[b] = 0.
  - Register r, q, den, ctr, sat, z and valid.
  - Compare and subtract at full NUM_W+1 width; no truncation.
- **Stage S9 (round/select).** Priority order:
  - z → ctr;
  - sat → 2^PIX_W-1;
  - 2r >= den and q != 255 → q+1;
  - otherwise → q.
  - Result: ties round up, and 255.5 clamps to 255.
- **Output update.** pix_out loads only when the S9 valid bit is 1. Otherwise it holds its last value.
- **No backpressure.** The block is always ready. Gaps in in_valid propagate unchanged as gaps in out_valid.
- **Reset.**
  - rst_n low clears every valid bit, pix_out = 0 and out_valid = 0.
  - Data pipeline registers may also be cleared, but this is not required.
  - Samples in flight at reset are discarded and never emerge.
- **Boundary cases.**
  - den==0 with num != 0 → ctr; no divide fault.
  - num==0 with den != 0 → 0.
  - num==den<<PIX_W exactly → sat → 255.

## Timing
- Latency is 10 cycles: in_valid high at rising edge t → out_valid high after rising edge t+10, with the matching pix_out.
- Throughput is 1 sample per clock. Back-to-back inputs produce back-to-back outputs in order.
- out_valid is registered and is a single-cycle pulse per accepted sample.
- Reset behaviour:
  - Asynchronous assertion forces out_valid = 0 and pix_out = 0 immediately.
  - The first sample accepted after release appears 10 cycles later.
  - No stale data escapes.
- The critical path is one (NUM_W+1)-bit compare/subtract per stage. No stage contains more than one subtractor.

## Test plan
- **Exact quotients.** num=2550, den=10 → pix_out=255 (not via sat). num=1000, den=9 → 111. num=1004, den=9 → 112 (111.56 rounds up).
- **Rounding tie and clamp.** num=5, den=10 → 1. num=2555, den=10 → 255, not 256. num=2560, den=10 → 255 via sat.
- **Zero cases.**
  - den=0, num=1234, ctr=0x5A → 0x5A.
  - den=0, num=0, ctr=0x00 → 0x00.
  - num=0, den=2295 → 0.
- **Extremes.** num=1048575, den=1 → 255. num=2295*200, den=2295 → 200.
- **Streaming.** Drive 12 consecutive valid samples with random num ≤ 2295*255 and den in 1..2295. Then insert gaps: valid pattern 1,0,0,1,1,0,1. Outputs must:
  - match the reference model in order, each exactly 10 cycles later;
  - reproduce the gap pattern;
  - hold pix_out unchanged during gaps.
- **Reset mid-stream.** Feed 3 samples at cycles 0–2, then pull rst_n low at cycle 4 for 2 cycles. Required response:
  - out_valid stays 0 and pix_out=0 throughout;
  - none of the 3 samples ever emerge;
  - a new sample at cycle 8 emerges at cycle 18 with the correct value.
